// File: rtl/imem_uart_loader.sv
// UART-fed program loader: receives framed 16-bit words, writes them to instruction
// memory and gates CPU execution on a verified checksum.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT_CLKS = 50000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX,
  output logic              WE,
  output logic [ADDR_W-1:0] WADDR,
  output logic [15:0]       WDATA,
  output logic              CPU_RUN,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [7:0]        WORD_CNT
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA_HI, S_DATA_LO, S_CSUM, S_ERROR} state_t;

  rx_state_t        r_rx_state, w_rx_nxt;
  logic             r_rx_s1, r_rx_s2, r_rx_prev;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_vld, r_frame_err;
  logic             w_tick_half, w_tick_bit;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_len, r_csum, r_hi, r_word_cnt;
  logic [TMR_W-1:0] r_timer;
  logic             r_we, r_cpu_run, r_busy, r_done, r_err;
  logic [ADDR_W-1:0] r_waddr;
  logic [15:0]      r_wdata;
  logic             w_in_frame, w_start, w_timeout;
  logic [7:0]       w_cnt_inc;

  assign w_tick_half = (r_clk_cnt == HALF_LAST);
  assign w_tick_bit  = (r_clk_cnt == BIT_LAST);

  always_comb begin
    w_rx_nxt = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (r_rx_prev && !r_rx_s2) w_rx_nxt = RX_START;
      RX_START: if (w_tick_half) w_rx_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick_bit && r_bit_idx == 3'd7) w_rx_nxt = RX_STOP;
      RX_STOP:  if (w_tick_bit) w_rx_nxt = RX_IDLE;
      default:  w_rx_nxt = RX_IDLE;
    endcase
  end

  // Receiver: synchronizer, edge detect, mid-bit sampling counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_s1     <= RX;
      r_rx_s2     <= r_rx_s1;
      r_rx_prev   <= r_rx_s2;
      r_rx_state  <= w_rx_nxt;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
        end
        RX_START: r_clk_cnt <= w_tick_half ? '0 : r_clk_cnt + 1'b1;
        RX_DATA: begin
          if (w_tick_bit) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_s2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_tick_bit) begin
            r_clk_cnt   <= '0;
            r_byte_vld  <= r_rx_s2;
            r_frame_err <= !r_rx_s2;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_clk_cnt <= '0;
      endcase
    end
  end

  assign w_in_frame = (r_state == S_LEN) || (r_state == S_DATA_HI) ||
                      (r_state == S_DATA_LO) || (r_state == S_CSUM);
  assign w_start    = r_byte_vld && (r_shift == SYNC_BYTE) &&
                      ((r_state == S_IDLE) || (r_state == S_ERROR));
  assign w_timeout  = w_in_frame && (r_timer == TMR_LAST);
  assign w_cnt_inc  = r_word_cnt + 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ERROR: if (w_start) w_state_nxt = S_LEN;
      S_LEN:     if (r_byte_vld) w_state_nxt = (r_shift == 8'd0) ? S_ERROR : S_DATA_HI;
      S_DATA_HI: if (r_byte_vld) w_state_nxt = S_DATA_LO;
      S_DATA_LO: if (r_byte_vld) w_state_nxt = (w_cnt_inc == r_len) ? S_CSUM : S_DATA_HI;
      S_CSUM:    if (r_byte_vld) w_state_nxt = (r_shift == r_csum) ? S_IDLE : S_ERROR;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (w_in_frame && (r_frame_err || w_timeout)) w_state_nxt = S_ERROR;
  end

  // Frame sequencer: write port, checksum, status flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_cpu_run  <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_word_cnt <= '0;
      r_len      <= '0;
      r_csum     <= '0;
      r_hi       <= '0;
      r_timer    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= 1'b0;
      r_timer <= (w_in_frame && !r_byte_vld) ? r_timer + 1'b1 : '0;
      if (w_start) begin
        r_busy     <= 1'b1;
        r_cpu_run  <= 1'b0;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
        r_word_cnt <= '0;
        r_csum     <= '0;
      end
      if (r_state == S_LEN && w_state_nxt == S_DATA_HI) begin
        r_len  <= r_shift;
        r_csum <= r_shift;
      end
      if (r_state == S_DATA_HI && w_state_nxt == S_DATA_LO) begin
        r_hi   <= r_shift;
        r_csum <= r_csum ^ r_shift;
      end
      if (r_state == S_DATA_LO && r_byte_vld && w_state_nxt != S_ERROR) begin
        r_we       <= 1'b1;
        r_waddr    <= ADDR_W'(r_word_cnt);
        r_wdata    <= {r_hi, r_shift};
        r_word_cnt <= w_cnt_inc;
        r_csum     <= r_csum ^ r_shift;
      end
      if (r_state == S_CSUM && w_state_nxt == S_IDLE) begin
        r_done    <= 1'b1;
        r_busy    <= 1'b0;
        r_cpu_run <= 1'b1;
      end
      if (w_state_nxt == S_ERROR && r_state != S_ERROR) begin
        r_err     <= 1'b1;
        r_busy    <= 1'b0;
        r_cpu_run <= 1'b0;
      end
    end
  end

  assign WE       = r_we;
  assign WADDR    = r_waddr;
  assign WDATA    = r_wdata;
  assign CPU_RUN  = r_cpu_run;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign ERR      = r_err;
  assign WORD_CNT = r_word_cnt;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: directed UART frames, write-port scoreboard and status checks.
module tb_imem_uart_loader;
  localparam int CPB  = 8;
  localparam int AW   = 8;
  localparam int TOUT = 2000;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX  = 1'b1;
  logic          WE;
  logic [AW-1:0] WADDR;
  logic [15:0]   WDATA;
  logic          CPU_RUN, BUSY, DONE, ERR;
  logic [7:0]    WORD_CNT;

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;
  wr_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .TIMEOUT_CLKS(TOUT)) dut (
    .CLK(CLK), .RST(RST), .RX(RX), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .CPU_RUN(CPU_RUN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .WORD_CNT(WORD_CNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Write-port monitor: every WE pulse must match the next expected write
  always @(negedge CLK) begin
    if (WE === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_we: got addr %0h data %0h, required no write", WADDR, WDATA);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (WADDR !== e.a || WDATA !== e.d) begin
          n_fail++;
          $display("FAIL write: got addr %0h data %0h, required addr %0h data %0h",
                   WADDR, WDATA, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge CLK);
    RX = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RX = stop;
    repeat (CPB) @(negedge CLK);
    RX = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic good_frame();
    push(8'd0, 16'h6000);
    push(8'd1, 16'h7001);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h60, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h70, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h13, 1'b1);
    cycles(4);
  endtask

  initial begin
    cycles(5);
    RST = 1'b0;
    cycles(2);
    chk("rst_cpu_run", CPU_RUN, 1);
    chk("rst_we", WE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_word_cnt", WORD_CNT, 0);
    chk("rst_waddr", WADDR, 0);
    chk("rst_wdata", WDATA, 0);

    // Noise bytes before sync, then a valid two-word frame
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    cycles(4);
    chk("noise_busy", BUSY, 0);
    chk("noise_cpu_run", CPU_RUN, 1);
    push(8'd0, 16'h6000);
    push(8'd1, 16'h7001);
    send_byte(8'hA5, 1'b1);
    cycles(2);
    chk("sync_cpu_run", CPU_RUN, 0);
    chk("sync_busy", BUSY, 1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h60, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h70, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h13, 1'b1);
    cycles(4);
    chk("ok_done", DONE, 1);
    chk("ok_cpu_run", CPU_RUN, 1);
    chk("ok_word_cnt", WORD_CNT, 2);
    chk("ok_err", ERR, 0);
    chk("ok_busy", BUSY, 0);
    chk("ok_waddr_hold", WADDR, 1);
    chk("ok_wdata_hold", WDATA, 16'h7001);
    chk("ok_writes_seen", exp_q.size(), 0);

    // Bad checksum, then recovery with a valid frame
    push(8'd0, 16'h6000);
    push(8'd1, 16'h7001);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h60, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h70, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h14, 1'b1);
    cycles(4);
    chk("csum_err", ERR, 1);
    chk("csum_cpu_run", CPU_RUN, 0);
    chk("csum_done", DONE, 0);
    chk("csum_word_cnt", WORD_CNT, 2);
    chk("csum_writes_seen", exp_q.size(), 0);
    good_frame();
    chk("recover_err", ERR, 0);
    chk("recover_done", DONE, 1);
    chk("recover_cpu_run", CPU_RUN, 1);
    chk("recover_writes_seen", exp_q.size(), 0);

    // Zero length frame
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    cycles(4);
    chk("len0_err", ERR, 1);
    chk("len0_cpu_run", CPU_RUN, 0);
    chk("len0_busy", BUSY, 0);

    // Framing error on the first data byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    cycles(2);
    chk("ferr_pre_err", ERR, 0);
    chk("ferr_pre_busy", BUSY, 1);
    send_byte(8'h60, 1'b0);
    cycles(4);
    chk("ferr_err", ERR, 1);
    chk("ferr_busy", BUSY, 0);
    chk("ferr_word_cnt", WORD_CNT, 0);

    // Inter-byte timeout after one word of three
    push(8'd0, 16'h6000);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h60, 1'b1);
    send_byte(8'h00, 1'b1);
    cycles(100);
    chk("tout_pre_err", ERR, 0);
    chk("tout_pre_word_cnt", WORD_CNT, 1);
    cycles(TOUT);
    chk("tout_err", ERR, 1);
    chk("tout_cpu_run", CPU_RUN, 0);
    chk("tout_word_cnt", WORD_CNT, 1);
    chk("tout_writes_seen", exp_q.size(), 0);

    // Reset in the middle of the second word of a four-word frame
    push(8'd0, 16'h1234);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    cycles(2);
    chk("mrst_cpu_run", CPU_RUN, 1);
    chk("mrst_busy", BUSY, 0);
    chk("mrst_err", ERR, 0);
    chk("mrst_word_cnt", WORD_CNT, 0);
    chk("mrst_wdata", WDATA, 0);
    send_byte(8'h78, 1'b1);
    send_byte(8'h9A, 1'b1);
    send_byte(8'hBC, 1'b1);
    send_byte(8'hDE, 1'b1);
    cycles(4);
    chk("mrst_after_busy", BUSY, 0);
    chk("mrst_after_cpu_run", CPU_RUN, 1);
    chk("mrst_writes_seen", exp_q.size(), 0);

    // One-cycle low glitch in idle, then a frame that needs an intact receiver
    @(negedge CLK);
    RX = 1'b0;
    @(negedge CLK);
    RX = 1'b1;
    cycles(40);
    chk("glitch_busy", BUSY, 0);
    chk("glitch_err", ERR, 0);
    chk("glitch_done", DONE, 0);
    push(8'd0, 16'hABCD);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'h67, 1'b1);
    cycles(4);
    chk("glitch_frame_done", DONE, 1);
    chk("glitch_frame_word_cnt", WORD_CNT, 1);
    chk("glitch_frame_err", ERR, 0);
    chk("glitch_writes_seen", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
